// File: rtl/seq_detect_pkg.sv
// Shared types, default parameters and width helper for the sequence detector scheduler.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int         DEF_NREQ    = 4;
    localparam int         DEF_FRAME_W = 8;
    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PAT_RST = 4'b1011;

    // Returns at least 1 so that single-value fields still get a real bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Rotating-priority arbiter: searches upward from last_i+1 with wrap, one-hot grant when enabled.
module rr_arbiter
    import seq_detect_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]        req_i,
    input  logic                   en_i,
    input  logic [clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [clog2(NREQ)-1:0] id_o,
    output logic                   valid_o
);

    localparam int ID_W = clog2(NREQ);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        id_o    = '0;
        valid_o = 1'b0;
        idx     = '0;
        // i = NREQ wraps back to last_i itself, so it is searched last.
        for (int i = 1; i <= NREQ; i++) begin
            idx = last_i + ID_W'(i);
            if (en_i && !valid_o && req_i[idx]) begin
                valid_o    = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = idx;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin frame scheduler feeding a shared serial pattern detector; reports match count and first hit.
//  state  | meaning
//  IDLE   | arbitrate requests, or accept a config write when nothing is granted
//  SHIFT  | shift one frame bit per cycle (MSB first) through the detector window
//  REPORT | pulse done and publish the result registers
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int               NREQ    = DEF_NREQ,
    parameter int               FRAME_W = DEF_FRAME_W,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RST = DEF_PAT_RST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [PAT_W-1:0]              cfg_pattern,
    input  logic                          cfg_overlap,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*FRAME_W-1:0]       frame_i,
    output logic [NREQ-1:0]               gnt,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(NREQ)-1:0]        done_id,
    output logic [clog2(FRAME_W+1)-1:0]   match_cnt,
    output logic [clog2(FRAME_W)-1:0]     first_pos
);

    localparam int ID_W   = clog2(NREQ);
    localparam int CNT_W  = clog2(FRAME_W + 1);
    localparam int POS_W  = clog2(FRAME_W);
    localparam int FILL_W = clog2(PAT_W + 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [PAT_W-1:0]    win_q, win_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [POS_W-1:0]    bcnt_q, bcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POS_W-1:0]    first_q, first_d;
    logic                seen_q, seen_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [POS_W-1:0]    first_pos_q, first_pos_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                ovl_q, ovl_d;

    logic                arb_en, arb_valid;
    logic [NREQ-1:0]     arb_gnt;
    logic [ID_W-1:0]     arb_id;
    logic [PAT_W-1:0]    win_nx;
    logic [FILL_W-1:0]   fill_nx;
    logic [POS_W-1:0]    cur_pos;
    logic                hit;

    // Gating with rst keeps gnt low for the whole reset assertion, not just after the first edge.
    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (req),
        .en_i    (arb_en),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .id_o    (arb_id),
        .valid_o (arb_valid)
    );

    // bcnt_q counts down, so the bit index being shifted is its complement from FRAME_W-1.
    assign win_nx  = (win_q << 1) | PAT_W'(frame_q[FRAME_W-1]);
    assign fill_nx = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    assign cur_pos = POS_W'(FRAME_W - 1) - bcnt_q;
    assign hit     = (fill_nx == FILL_W'(PAT_W)) && (win_nx == pat_q);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_id_d    = cur_id_q;
        frame_d     = frame_q;
        win_d       = win_q;
        fill_d      = fill_q;
        bcnt_d      = bcnt_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        seen_d      = seen_q;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        first_pos_d = first_pos_q;
        pat_d       = pat_q;
        ovl_d       = ovl_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    last_d   = arb_id;
                    cur_id_d = arb_id;
                    frame_d  = frame_i[int'(arb_id)*FRAME_W +: FRAME_W];
                    win_d    = '0;
                    fill_d   = '0;
                    bcnt_d   = POS_W'(FRAME_W - 1);
                    cnt_d    = '0;
                    first_d  = '0;
                    seen_d   = 1'b0;
                    state_d  = SHIFT;
                end else if (cfg_we) begin
                    pat_d = cfg_pattern;
                    ovl_d = cfg_overlap;
                end
            end
            SHIFT: begin
                frame_d = frame_q << 1;
                win_d   = win_nx;
                fill_d  = fill_nx;
                if (hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!seen_q) begin
                        seen_d  = 1'b1;
                        first_d = cur_pos;
                    end
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                end
                if (bcnt_q == '0) begin
                    state_d     = REPORT;
                    done_id_d   = cur_id_q;
                    match_cnt_d = cnt_d;
                    first_pos_d = first_d;
                end else begin
                    bcnt_d = bcnt_q - POS_W'(1);
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NREQ - 1);
            cur_id_q    <= '0;
            frame_q     <= '0;
            win_q       <= '0;
            fill_q      <= '0;
            bcnt_q      <= '0;
            cnt_q       <= '0;
            first_q     <= '0;
            seen_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            first_pos_q <= '0;
            pat_q       <= PAT_RST;
            ovl_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_id_q    <= cur_id_d;
            frame_q     <= frame_d;
            win_q       <= win_d;
            fill_q      <= fill_d;
            bcnt_q      <= bcnt_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            seen_q      <= seen_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
            first_pos_q <= first_pos_d;
            pat_q       <= pat_d;
            ovl_q       <= ovl_d;
        end
    end

    assign gnt       = arb_gnt;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == REPORT);
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
    assign first_pos = first_pos_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: expected reports queued at stimulus, checked on each done pulse.
module tb_seq_detect_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_pattern;
    logic        cfg_overlap;
    logic [3:0]  req;
    logic [31:0] frame_i;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  match_cnt;
    logic [2:0]  first_pos;

    typedef struct {
        int id;
        int cnt;
        int pos;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   gcyc         = 0;

    seq_detect_sched dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .req         (req),
        .frame_i     (frame_i),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .match_cnt   (match_cnt),
        .first_pos   (first_pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference detector: slides a 4-bit window over the frame MSB first.
    function automatic void model(input logic [7:0] fr, input logic [3:0] pat, input logic ovl,
                                  output int cnt, output int pos);
        logic [3:0] w;
        int fill;
        w = '0;
        fill = 0;
        cnt = 0;
        pos = 0;
        for (int i = 0; i < 8; i++) begin
            w = {w[2:0], fr[7-i]};
            if (fill < 4) fill++;
            if (fill == 4 && w == pat) begin
                if (cnt == 0) pos = i;
                cnt++;
                if (!ovl) fill = 0;
            end
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gnt != 4'b0) gcyc = cyc;
            if (done) begin
                chk("done_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), e.id);
                    chk("match_cnt", 32'(match_cnt), e.cnt);
                    chk("first_pos", 32'(first_pos), e.pos);
                    chk("gnt_to_done", cyc - gcyc, 32'd9);
                end
            end
        end
    end

    task automatic wait_gnt(output int c);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == 4'b0 && t < 40);
        c = cyc;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req = '0;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] pat, input logic ovl);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // mode 1: pattern write of 0000 mid-SHIFT; mode 2: pattern write of 1111 in the grant cycle.
    task automatic run_frame(input int k, input logic [7:0] fr, input int ecnt, input int epos, input int mode);
        int c;
        @(posedge clk); #1;
        frame_i[k*8 +: 8] = fr;
        req[k] = 1'b1;
        if (mode == 2) begin
            cfg_we = 1'b1;
            cfg_pattern = 4'b1111;
            cfg_overlap = 1'b1;
        end
        sb.push_back('{k, ecnt, epos});
        wait_gnt(c);
        chk("gnt", 32'(gnt), 32'(1 << k));
        @(posedge clk); #1;
        req[k] = 1'b0;
        cfg_we = 1'b0;
        if (mode == 1) begin
            @(posedge clk); #1;
            cfg_we = 1'b1;
            cfg_pattern = 4'b0000;
            @(posedge clk); #1;
            cfg_we = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        int c, prev, nd, ecnt, epos, k;
        logic [7:0] fr;
        logic [3:0] pat;
        logic ovl;

        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_pattern = 4'b0;
        cfg_overlap = 1'b1;
        req = '0;
        frame_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
        chk("rst_first_pos", 32'(first_pos), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic matching, overlap on and off.
        set_cfg(4'b1011, 1'b1);
        run_frame(0, 8'b0101_1011, 2, 4, 0);
        set_cfg(4'b1011, 1'b0);
        run_frame(0, 8'b0101_1011, 1, 4, 0);
        set_cfg(4'b1111, 1'b1);
        run_frame(1, 8'hFF, 5, 3, 0);
        set_cfg(4'b1111, 1'b0);
        run_frame(2, 8'hFF, 2, 3, 0);

        // Round robin with all requests held.
        do_reset();
        @(posedge clk); #1;
        frame_i = '0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) sb.push_back('{n % 4, 0, 0});
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(c);
            chk("rr_gnt", 32'(gnt), 32'(1 << (n % 4)));
            if (n > 0) chk("rr_spacing", c - prev, 32'd10);
            prev = c;
        end
        @(posedge clk); #1;
        req = '0;
        wait_idle();

        // Config writes: ignored during SHIFT, applied in idle, dropped when colliding with a grant.
        run_frame(0, 8'b0101_1011, 2, 4, 1);
        set_cfg(4'b0000, 1'b1);
        run_frame(1, 8'h00, 5, 3, 0);
        set_cfg(4'b1011, 1'b1);
        run_frame(3, 8'hFF, 0, 0, 2);
        run_frame(1, 8'b0101_1011, 2, 4, 0);

        run_frame(0, 8'b1000_0000, 0, 0, 0);
        run_frame(2, 8'b1011_1011, 2, 3, 0);

        // Reset in the middle of a frame.
        set_cfg(4'b1111, 1'b0);
        @(posedge clk); #1;
        frame_i[8 +: 8] = 8'hFF;
        req[1] = 1'b1;
        wait_gnt(c);
        chk("pre_rst_gnt", 32'(gnt), 32'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_match_cnt", 32'(match_cnt), 32'd0);
        chk("async_first_pos", 32'(first_pos), 32'd0);
        chk("async_done_id", 32'(done_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", nd, 32'd0);
        @(posedge clk); #1;
        frame_i[0 +: 8] = 8'b0101_1011;
        frame_i[16 +: 8] = 8'b1011_1011;
        req = 4'b0101;
        sb.push_back('{0, 2, 4});
        sb.push_back('{2, 2, 3});
        wait_gnt(c);
        chk("post_rst_gnt", 32'(gnt), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_gnt(c);
        chk("post_rst_gnt2", 32'(gnt), 32'd4);
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_idle();

        // Random frames against the reference model.
        for (int n = 0; n < 6; n++) begin
            k = $urandom_range(0, 3);
            fr = 8'($urandom);
            pat = 4'($urandom);
            ovl = 1'($urandom);
            set_cfg(pat, ovl);
            model(fr, pat, ovl, ecnt, epos);
            run_frame(k, fr, ecnt, epos, 0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler and controller for a shared serial bit-pattern detector. Up to NREQ requesters each present a parallel frame. The block grants one requester at a time and serialises the granted frame MSB-first through an internal PAT_W-bit detector window. It then reports the match count and the position of the first match. It sits between frame producers and the status/interrupt logic, and owns the detector's pattern and overlap configuration.

## Interface
Parameters:
- NREQ, 4, number of requesters; must be a power of two, ≥2.
- FRAME_W, 8, bits per frame.
- PAT_W, 4, pattern length; 1 ≤ PAT_W ≤ FRAME_W.
- PAT_RST, 4'b1011, pattern value after reset.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cfg_we, input, 1: configuration write strobe; honoured only in IDLE.
- cfg_pattern, input, PAT_W: new pattern.
- cfg_overlap, input, 1: 1 = overlapping matches counted; 0 = window cleared after each match.
- req, input, NREQ: per-requester frame request; level, held until granted.
- frame_i, input, NREQ*FRAME_W: requester k's frame is at bits [k*FRAME_W +: FRAME_W].
- gnt, output, NREQ: one-hot, one-cycle pulse; frame is captured that cycle.
- busy, output, 1: high in SHIFT and REPORT.
- done, output, 1: one-cycle pulse in REPORT.
- done_id, output, log2(NREQ): requester index of the reported frame.
- match_cnt, output, clog2(FRAME_W+1): number of matches in the frame.
- first_pos, output, clog2(FRAME_W): bit index (0 = MSB) at which the first match completed; 0 if match_cnt = 0.

## Operation
- States: IDLE, SHIFT, REPORT.
- IDLE:
  - If req ≠ 0, select the first set bit searching upward (with wrap) from last_gnt+1.
  - Pulse gnt for that bit, latch its frame, done_id and the pointer.
  - Clear the window, bit counter, fill counter, match_cnt accumulator and first-hit flag, then go to SHIFT.
  - cfg_we is applied in IDLE only, and only on a cycle with no grant. If cfg_we and req ≠ 0 arrive together, the grant wins and the write is dropped.
- SHIFT: each cycle, shift the next frame bit (MSB first) into the window and increment the fill counter (saturating at PAT_W).
  - A match occurs when the fill counter reaches PAT_W and the window equals the pattern.
  - On a match, increment the count. On the first match, record the bit index in first_pos.
  - With overlap = 0, reset the fill counter to 0 after each match.
  - After bit FRAME_W-1, go to REPORT.
- REPORT: pulse done, drive match_cnt, first_pos and done_id, then go to IDLE.
  - Report outputs hold their values until the next REPORT.
- Pattern and overlap are sampled once at grant and remain stable for the whole frame.
- A requester that drops req before being granted is simply not granted; there is no error.
- Reset values:
  - State IDLE.
  - gnt, busy, done, done_id, match_cnt, first_pos all 0.
  - last_gnt = NREQ-1, so the first grant searches from requester 0.
  - Pattern PAT_RST, overlap 1.

## Timing
- Grant cycle to first shifted bit: 1 cycle.
- Grant to done pulse: FRAME_W+1 cycles.
- Back-to-back service: the next grant can occur in the cycle after done. Minimum frame period is FRAME_W+2 cycles.
- Asserting rst in any state, mid-frame included, immediately forces all outputs to their reset values. The in-flight frame is discarded and no done is issued.
- gnt is never asserted while busy = 1.

## Structure
- Package seq_detect_pkg holds:
  - the state enum (IDLE/SHIFT/REPORT);
  - the default parameter constants;
  - a clog2 function.
- Sub-module rr_arbiter (NREQ-wide, rotating-priority, one-hot grant with an enable input) keeps the arbitration logic separate from the serialiser FSM.

## Test plan
- Reset, then cfg_pattern 4'b1011 with overlap=1. req[0] with frame 8'b0101_1011: gnt=4'b0001, and done exactly 9 cycles later with match_cnt=2, first_pos=4, done_id=0.
- Same frame with overlap=0: match_cnt=1, first_pos=4. Pattern 4'b1111 with frame 8'hFF gives match_cnt=5 for overlap=1 and match_cnt=2 for overlap=0.
- req=4'b1111 held continuously, all frames 8'h00: grants in order 0,1,2,3,0. Each done reports match_cnt=0 and first_pos=0. Grants are spaced 10 cycles apart.
- cfg_we with pattern 4'b0000 during SHIFT is ignored, so the current frame still uses 1011. The same write issued in IDLE with req=0 takes effect on the next frame.
- Assert rst 3 cycles into SHIFT: busy and gnt drop asynchronously. After release, no done is seen. The next grant goes to requester 0 and the pattern reads back as PAT_RST.
- Frame 8'b1000_0000 with pattern 4'b1011: match_cnt=0 and first_pos=0. Then requester 2 alone with frame 8'b1011_1011: gnt=4'b0100, match_cnt=2, first_pos=3, done_id=2.
